// File: rtl/regfile_param.sv
// ============================================================================
// Module      : regfile_param
// Description : Parameterised register file with two registered read ports, a
//               per-register busy scoreboard and a combinational debug port.
//               Optional write-to-read forwarding is enabled by defining
//               REGFILE_BYPASS_EN.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module regfile_param #(
    parameter int WIDTH    = 8,
    parameter int ADDR_W   = 3,
    parameter int ZERO_REG = 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              we,
    input  logic [ADDR_W-1:0] wa,
    input  logic [WIDTH-1:0]  wd,
    input  logic              re1,
    input  logic [ADDR_W-1:0] ra1,
    output logic [WIDTH-1:0]  rd1,
    input  logic              re2,
    input  logic [ADDR_W-1:0] ra2,
    output logic [WIDTH-1:0]  rd2,
    input  logic              mark_en,
    input  logic [ADDR_W-1:0] mark_addr,
    output logic              busy1,
    output logic              busy2,
    input  logic [ADDR_W-1:0] dbg_addr,
    output logic [WIDTH-1:0]  dbg_data
);

    localparam int DEPTH = 1 << ADDR_W;

`ifdef REGFILE_BYPASS_EN
    localparam bit c_bypass = 1'b1;
`else
    localparam bit c_bypass = 1'b0;
`endif

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [DEPTH-1:0] r_busy;
    logic [DEPTH-1:0] w_busy_nxt;
    logic [WIDTH-1:0] r_rd1;
    logic [WIDTH-1:0] r_rd2;
    logic [WIDTH-1:0] w_rd1_nxt;
    logic [WIDTH-1:0] w_rd2_nxt;
    logic             w_wr_ok;
    logic             w_mark_ok;

    // Register 0 is never written when hardwired, so it stays at its reset zero.
    assign w_wr_ok   = we      && !((ZERO_REG != 0) && (wa == '0));
    assign w_mark_ok = mark_en && !((ZERO_REG != 0) && (mark_addr == '0));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_mem[i] <= '0;
            end
        end else if (w_wr_ok) begin
            r_mem[wa] <= wd;
        end
    end

    // Mark is applied after the write clear so a same-cycle mark wins.
    always_comb begin
        w_busy_nxt = r_busy;
        if (w_wr_ok) begin
            w_busy_nxt[wa] = 1'b0;
        end
        if (w_mark_ok) begin
            w_busy_nxt[mark_addr] = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_busy <= '0;
        end else begin
            r_busy <= w_busy_nxt;
        end
    end

    always_comb begin
        w_rd1_nxt = r_mem[ra1];
        w_rd2_nxt = r_mem[ra2];
        if (c_bypass && w_wr_ok && (wa == ra1)) begin
            w_rd1_nxt = wd;
        end
        if (c_bypass && w_wr_ok && (wa == ra2)) begin
            w_rd2_nxt = wd;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rd1 <= '0;
            r_rd2 <= '0;
        end else begin
            if (re1) begin
                r_rd1 <= w_rd1_nxt;
            end
            if (re2) begin
                r_rd2 <= w_rd2_nxt;
            end
        end
    end

    assign rd1      = r_rd1;
    assign rd2      = r_rd2;
    assign busy1    = r_busy[ra1];
    assign busy2    = r_busy[ra2];
    assign dbg_data = r_mem[dbg_addr];

endmodule

`default_nettype wire
